// File: rtl/pool_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pool_pkg : shared types and elaboration helpers for multi_pool_unit   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package pool_pkg;

  typedef enum logic [1:0] {
    POOL_MAX = 2'd0,
    POOL_AVG = 2'd1,
    POOL_MIN = 2'd2,
    POOL_SUB = 2'd3
  } pool_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Counter width that stays legal for a count of one.
  function automatic int bits_for(input int count);
    return (count <= 1) ? 1 : clog2(count);
  endfunction

  function automatic int out_dim(input int map_dim, input int stride);
    return (map_dim - 1) / stride + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_pool_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_pool_unit_if : pooled-element valid/ready stream                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface multi_pool_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  elem_valid;
  logic                  elem_ready;
  logic [DATA_WIDTH-1:0] elem_data;
  logic                  elem_last;

  modport master (output elem_valid, output elem_data, output elem_last, input elem_ready);
  modport slave  (input elem_valid, input elem_data, input elem_last, output elem_ready);
endinterface
`default_nettype wire

// File: rtl/pool_reducer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pool_reducer : sequential window reduction (max/avg/min/subsample)    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pool_reducer
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int POOL_SIZE  = 2,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  en,
  input  logic                  pad,
  input  pool_mode_e            mode,
  input  logic [DATA_WIDTH-1:0] element,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SHIFT = 2 * clog2(POOL_SIZE);
  localparam int ACC_W = DATA_WIDTH + SHIFT;

  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      acc_d;
  logic [ACC_W-1:0]      elem_ext;
  logic                  elem_gt;
  logic                  elem_lt;
  logic [DATA_WIDTH-1:0] avg_result;

  // The accumulator keeps the element extended to full width so that the
  // same compare serves max/min and the same adder serves averaging.
  generate
    if (SIGNED != 0) begin : g_signed
      assign elem_ext   = ACC_W'($signed(element));
      assign elem_gt    = $signed(elem_ext) > $signed(acc_q);
      assign elem_lt    = $signed(elem_ext) < $signed(acc_q);
      assign avg_result = DATA_WIDTH'($signed(acc_q) >>> SHIFT);
    end else begin : g_unsigned
      assign elem_ext   = ACC_W'(element);
      assign elem_gt    = elem_ext > acc_q;
      assign elem_lt    = elem_ext < acc_q;
      assign avg_result = DATA_WIDTH'(acc_q >> SHIFT);
    end
  endgenerate

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      if (init) begin
        acc_d = elem_ext;
      end else if (!pad) begin
        case (mode)
          POOL_MAX: if (elem_gt) acc_d = elem_ext;
          POOL_MIN: if (elem_lt) acc_d = elem_ext;
          POOL_AVG: acc_d = acc_q + elem_ext;
          default:  acc_d = acc_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign result = (mode == POOL_AVG) ? avg_result : acc_q[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/multi_pool_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_pool_unit : strided windowed pooling with element stream output |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module multi_pool_unit
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MAP_HEIGHT   = 7,
  parameter int MAP_WIDTH    = 7,
  parameter int NUM_CHANNELS = 6,
  parameter int POOL_SIZE    = 2,
  parameter int POOL_STRIDE  = 2,
  parameter int SIGNED       = 0,
  localparam int OUT_H    = out_dim(MAP_HEIGHT, POOL_STRIDE),
  localparam int OUT_W    = out_dim(MAP_WIDTH, POOL_STRIDE),
  localparam int IN_BITS  = DATA_WIDTH * MAP_HEIGHT * MAP_WIDTH * NUM_CHANNELS,
  localparam int OUT_BITS = DATA_WIDTH * OUT_H * OUT_W * NUM_CHANNELS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [1:0]          pool_mode,
  input  logic [IN_BITS-1:0]  input_value,
  output logic                busy,
  multi_pool_unit_if.master   elem_if,
  output logic [OUT_BITS-1:0] out_value,
  output logic                out_valid
);

  localparam int C_W  = bits_for(NUM_CHANNELS);
  localparam int OY_W = bits_for(OUT_H);
  localparam int OX_W = bits_for(OUT_W);
  localparam int P_W  = bits_for(POOL_SIZE);

  localparam logic [C_W-1:0]  C_LAST  = C_W'(NUM_CHANNELS - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(OUT_H - 1);
  localparam logic [OX_W-1:0] OX_LAST = OX_W'(OUT_W - 1);
  localparam logic [P_W-1:0]  P_LAST  = P_W'(POOL_SIZE - 1);

  state_e                state_q, state_d;
  pool_mode_e            mode_q, mode_d;
  logic [IN_BITS-1:0]    frame_q, frame_d;
  logic [OUT_BITS-1:0]   buf_q, buf_d;
  logic [OUT_BITS-1:0]   out_value_q, out_value_d;
  logic [C_W-1:0]        c_q, c_d;
  logic [OY_W-1:0]       oy_q, oy_d;
  logic [OX_W-1:0]       ox_q, ox_d;
  logic [P_W-1:0]        py_q, py_d;
  logic [P_W-1:0]        px_q, px_d;

  int                    src_y;
  int                    src_x;
  int                    src_idx;
  int                    slot_idx;
  logic                  pad;
  logic                  last_elem;
  logic [DATA_WIDTH-1:0] element;
  logic [DATA_WIDTH-1:0] red_result;

  // Padding slots are redirected to index 0 so the select never leaves the frame.
  always_comb begin
    src_y    = int'(oy_q) * POOL_STRIDE + int'(py_q);
    src_x    = int'(ox_q) * POOL_STRIDE + int'(px_q);
    pad      = (src_y >= MAP_HEIGHT) || (src_x >= MAP_WIDTH);
    src_idx  = pad ? 0 : (int'(c_q) * MAP_HEIGHT + src_y) * MAP_WIDTH + src_x;
    slot_idx = (int'(c_q) * OUT_H + int'(oy_q)) * OUT_W + int'(ox_q);
  end

  assign element   = frame_q[src_idx*DATA_WIDTH +: DATA_WIDTH];
  assign last_elem = (c_q == C_LAST) && (oy_q == OY_LAST) && (ox_q == OX_LAST);

  pool_reducer #(
    .DATA_WIDTH (DATA_WIDTH),
    .POOL_SIZE  (POOL_SIZE),
    .SIGNED     (SIGNED)
  ) u_reducer (
    .clk     (clk),
    .rst     (rst),
    .init    ((py_q == '0) && (px_q == '0)),
    .en      (state_q == ST_ACCUM),
    .pad     (pad),
    .mode    (mode_q),
    .element (element),
    .result  (red_result)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    frame_d     = frame_q;
    buf_d       = buf_q;
    out_value_d = out_value_q;
    c_d         = c_q;
    oy_d        = oy_q;
    ox_d        = ox_q;
    py_d        = py_q;
    px_d        = px_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          frame_d = input_value;
          mode_d  = pool_mode_e'(pool_mode);
          c_d     = '0;
          oy_d    = '0;
          ox_d    = '0;
          py_d    = '0;
          px_d    = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (px_q == P_LAST) begin
          px_d = '0;
          if (py_q == P_LAST) begin
            py_d    = '0;
            state_d = ST_EMIT;
          end else begin
            py_d = py_q + 1'b1;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (elem_if.elem_ready) begin
          buf_d[slot_idx*DATA_WIDTH +: DATA_WIDTH] = red_result;
          if (last_elem) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
            if (ox_q == OX_LAST) begin
              ox_d = '0;
              if (oy_q == OY_LAST) begin
                oy_d = '0;
                c_d  = c_q + 1'b1;
              end else begin
                oy_d = oy_q + 1'b1;
              end
            end else begin
              ox_d = ox_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        out_value_d = buf_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= POOL_MAX;
      frame_q     <= '0;
      buf_q       <= '0;
      out_value_q <= '0;
      c_q         <= '0;
      oy_q        <= '0;
      ox_q        <= '0;
      py_q        <= '0;
      px_q        <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      frame_q     <= frame_d;
      buf_q       <= buf_d;
      out_value_q <= out_value_d;
      c_q         <= c_d;
      oy_q        <= oy_d;
      ox_q        <= ox_d;
      py_q        <= py_d;
      px_q        <= px_d;
    end
  end

  assign busy               = (state_q != ST_IDLE);
  assign out_valid          = (state_q == ST_DONE);
  assign out_value          = out_value_q;
  assign elem_if.elem_valid = (state_q == ST_EMIT);
  assign elem_if.elem_data  = (state_q == ST_EMIT) ? red_result : '0;
  assign elem_if.elem_last  = (state_q == ST_EMIT) && last_elem;

endmodule
`default_nettype wire

// File: tb/tb_multi_pool_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_multi_pool_unit : directed bench, 3x3x2 map, P=2 S=2, two SIGNED   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_multi_pool_unit;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [1:0]   mode;
  logic [143:0] img;
  logic         ready;
  logic         u_busy, s_busy, u_out_valid, s_out_valid;
  logic [63:0]  u_out_value, s_out_value;

  int n_cmp;
  int n_fail;

  logic [7:0] got_u [8];
  logic [7:0] got_s [8];
  logic [7:0] lst_vec;
  int         n_got, first_ev, last_hs, outv_cyc, outv_cnt;
  bit         stall_ok, tmo;

  multi_pool_unit_if #(.DATA_WIDTH(8)) u_if ();
  multi_pool_unit_if #(.DATA_WIDTH(8)) s_if ();

  assign u_if.elem_ready = ready;
  assign s_if.elem_ready = ready;

  multi_pool_unit #(
    .DATA_WIDTH(8), .MAP_HEIGHT(3), .MAP_WIDTH(3), .NUM_CHANNELS(2),
    .POOL_SIZE(2), .POOL_STRIDE(2), .SIGNED(0)
  ) dut_u (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pool_mode(mode), .input_value(img),
    .busy(u_busy), .elem_if(u_if), .out_value(u_out_value), .out_valid(u_out_valid)
  );

  multi_pool_unit #(
    .DATA_WIDTH(8), .MAP_HEIGHT(3), .MAP_WIDTH(3), .NUM_CHANNELS(2),
    .POOL_SIZE(2), .POOL_STRIDE(2), .SIGNED(1)
  ) dut_s (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pool_mode(mode), .input_value(img),
    .busy(s_busy), .elem_if(s_if), .out_value(s_out_value), .out_valid(s_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [143:0] put(input logic [143:0] im, input int c, input int y,
                                       input int x, input logic [7:0] v);
    logic [143:0] r;
    r = im;
    r[((c*3+y)*3+x)*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [143:0] seq_image();
    logic [143:0] r;
    r = '0;
    for (int c = 0; c < 2; c++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          r = put(r, c, y, x, 8'(1 + c*9 + y*3 + x));
    return r;
  endfunction

  // Drives one frame and records the stream; cycle 0 is the cycle valid_in is sampled.
  task automatic run_frame(input logic [1:0] m, input logic [143:0] im, input int stall_at,
                           input int stall_len, input bit poke);
    int         cyc;
    int         stall_left;
    bit         stall_used;
    logic [7:0] held;
    logic       held_last;
    n_got = 0; first_ev = -1; last_hs = -1; outv_cyc = -1; outv_cnt = 0;
    stall_ok = 1'b1; tmo = 1'b0; lst_vec = '0;
    stall_left = 0; stall_used = 1'b0; held = '0; held_last = 1'b0;
    for (int i = 0; i < 8; i++) begin got_u[i] = 'x; got_s[i] = 'x; end
    valid_in = 1'b1; mode = m; img = im; ready = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    valid_in = 1'b0;
    if (poke) mode = m ^ 2'b01;
    while (1) begin
      if (cyc > 200) begin tmo = 1'b1; break; end
      if (u_out_valid) begin
        outv_cnt++;
        if (outv_cyc < 0) outv_cyc = cyc;
      end
      if (!u_busy) break;
      if (u_if.elem_valid && first_ev < 0) first_ev = cyc;
      if (u_if.elem_valid && n_got == stall_at && !stall_used) begin
        stall_used = 1'b1; stall_left = stall_len;
        held = u_if.elem_data; held_last = u_if.elem_last;
      end
      if (stall_left > 0) begin
        if (!u_if.elem_valid || u_if.elem_data !== held || u_if.elem_last !== held_last)
          stall_ok = 1'b0;
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = 1'b1;
        if (u_if.elem_valid) begin
          if (n_got < 8) begin
            got_u[n_got] = u_if.elem_data;
            got_s[n_got] = s_if.elem_data;
            lst_vec[n_got] = u_if.elem_last;
          end
          n_got++;
          last_hs = cyc;
        end
      end
      valid_in = poke && (cyc == 7);
      if (poke && cyc == 7) img = ~im;
      @(posedge clk); #1;
      cyc++;
    end
    valid_in = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (u_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", u_busy); end
    n_cmp++; if (u_if.elem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_elem_valid got %b want 0", u_if.elem_valid); end
    n_cmp++; if (u_if.elem_last !== 1'b0) begin n_fail++; $display("FAIL reset_elem_last got %b want 0", u_if.elem_last); end
    n_cmp++; if (u_if.elem_data !== 8'h00) begin n_fail++; $display("FAIL reset_elem_data got %h want 00", u_if.elem_data); end
    n_cmp++; if (u_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", u_out_valid); end
    n_cmp++; if (u_out_value !== 64'h0) begin n_fail++; $display("FAIL reset_out_value got %h want 0", u_out_value); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mode(input logic [1:0] m, input string name, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                           input logic [7:0] e4, input logic [7:0] e5, input logic [7:0] e6,
                           input logic [7:0] e7);
    logic [7:0]  exp [8];
    logic [63:0] exp_frame;
    exp = '{e0, e1, e2, e3, e4, e5, e6, e7};
    exp_frame = {e7, e6, e5, e4, e3, e2, e1, e0};
    run_frame(m, seq_image(), -1, 0, 1'b0);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL %s_timeout got %b want 0", name, tmo); end
    n_cmp++; if (n_got != 8) begin n_fail++; $display("FAIL %s_count got %0d want 8", name, n_got); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_u[i] !== exp[i]) begin n_fail++; $display("FAIL %s_elem%0d got %h want %h", name, i, got_u[i], exp[i]); end
      n_cmp++;
      if (got_s[i] !== exp[i]) begin n_fail++; $display("FAIL %s_signed_elem%0d got %h want %h", name, i, got_s[i], exp[i]); end
    end
    n_cmp++; if (lst_vec !== 8'b1000_0000) begin n_fail++; $display("FAIL %s_last got %b want 10000000", name, lst_vec); end
    n_cmp++; if (first_ev != 5) begin n_fail++; $display("FAIL %s_first_latency got %0d want 5", name, first_ev); end
    n_cmp++; if (last_hs != 40) begin n_fail++; $display("FAIL %s_last_handshake got %0d want 40", name, last_hs); end
    n_cmp++; if (outv_cyc != 41 || outv_cnt != 1) begin n_fail++; $display("FAIL %s_out_valid got cyc %0d cnt %0d want 41/1", name, outv_cyc, outv_cnt); end
    n_cmp++; if (u_out_value !== exp_frame) begin n_fail++; $display("FAIL %s_out_value got %h want %h", name, u_out_value, exp_frame); end
  endtask

  task automatic test_signed();
    logic [143:0] im;
    im = put('0, 0, 0, 0, 8'hFF); im = put(im, 0, 0, 1, 8'h80);
    im = put(im, 0, 1, 0, 8'h01); im = put(im, 0, 1, 1, 8'h7F);
    run_frame(2'd0, im, -1, 0, 1'b0);
    n_cmp++; if (got_s[0] !== 8'h7F) begin n_fail++; $display("FAIL signed_max got %h want 7f", got_s[0]); end
    n_cmp++; if (got_u[0] !== 8'hFF) begin n_fail++; $display("FAIL unsigned_max got %h want ff", got_u[0]); end
    run_frame(2'd2, im, -1, 0, 1'b0);
    n_cmp++; if (got_s[0] !== 8'h80) begin n_fail++; $display("FAIL signed_min got %h want 80", got_s[0]); end
    n_cmp++; if (got_u[0] !== 8'h01) begin n_fail++; $display("FAIL unsigned_min got %h want 01", got_u[0]); end
    im = put('0, 0, 0, 0, 8'hFF); im = put(im, 0, 0, 1, 8'hFF);
    im = put(im, 0, 1, 0, 8'hFF); im = put(im, 0, 1, 1, 8'hFE);
    im = put(im, 0, 2, 2, 8'h80);
    run_frame(2'd1, im, -1, 0, 1'b0);
    n_cmp++; if (got_s[0] !== 8'hFE) begin n_fail++; $display("FAIL signed_avg got %h want fe", got_s[0]); end
    n_cmp++; if (got_u[0] !== 8'hFE) begin n_fail++; $display("FAIL unsigned_avg got %h want fe", got_u[0]); end
    n_cmp++; if (got_s[3] !== 8'hE0) begin n_fail++; $display("FAIL signed_avg_pad got %h want e0", got_s[3]); end
    n_cmp++; if (got_u[3] !== 8'h20) begin n_fail++; $display("FAIL unsigned_avg_pad got %h want 20", got_u[3]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [8];
    exp = '{8'd5, 8'd6, 8'd8, 8'd9, 8'd14, 8'd15, 8'd17, 8'd18};
    run_frame(2'd0, seq_image(), 1, 5, 1'b1);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b want 0", tmo); end
    n_cmp++; if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", stall_ok); end
    n_cmp++; if (n_got != 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_u[i] !== exp[i]) begin n_fail++; $display("FAIL bp_elem%0d got %h want %h", i, got_u[i], exp[i]); end
    end
    n_cmp++; if (last_hs != 45) begin n_fail++; $display("FAIL bp_last_handshake got %0d want 45", last_hs); end
    n_cmp++; if (outv_cyc != 46) begin n_fail++; $display("FAIL bp_out_valid got %0d want 46", outv_cyc); end
    n_cmp++; if (u_out_value !== 64'h1211_0F0E_0908_0605) begin n_fail++; $display("FAIL bp_out_value got %h want 12110f0e09080605", u_out_value); end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    int cyc;
    int outv_seen;
    valid_in = 1'b1; mode = 2'd0; img = seq_image(); ready = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 3 && cyc < 100) begin
      if (u_if.elem_valid) seen++;
      if (seen < 3) begin @(posedge clk); #1; cyc++; end
    end
    n_cmp++; if (seen != 3) begin n_fail++; $display("FAIL rstmid_reach_emit got %0d want 3", seen); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (u_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", u_busy); end
    n_cmp++; if (u_if.elem_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_elem_valid got %b want 0", u_if.elem_valid); end
    n_cmp++; if (u_out_value !== 64'h0) begin n_fail++; $display("FAIL rstmid_out_value got %h want 0", u_out_value); end
    outv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_out_valid) outv_seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (outv_seen != 0) begin n_fail++; $display("FAIL rstmid_no_out_valid got %0d want 0", outv_seen); end
    test_mode(2'd0, "after_rst", 8'd5, 8'd6, 8'd8, 8'd9, 8'd14, 8'd15, 8'd17, 8'd18);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; valid_in = 1'b0; mode = 2'd0; img = '0; ready = 1'b1;
    test_reset();
    test_mode(2'd0, "max", 8'd5, 8'd6, 8'd8, 8'd9, 8'd14, 8'd15, 8'd17, 8'd18);
    test_mode(2'd1, "avg", 8'd3, 8'd2, 8'd3, 8'd2, 8'd12, 8'd6, 8'd8, 8'd4);
    test_mode(2'd2, "min", 8'd1, 8'd3, 8'd7, 8'd9, 8'd10, 8'd12, 8'd16, 8'd18);
    test_mode(2'd3, "sub", 8'd1, 8'd3, 8'd7, 8'd9, 8'd10, 8'd12, 8'd16, 8'd18);
    test_signed();
    test_backpressure();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_pool_unit.md
Name: multi_pool_unit

Overview:
- Parametrised successor to the current pooling stage. Adds configurable stride, four pooling modes, signed/unsigned data, edge padding and a per-element valid/ready output stream with backpressure.
- Consumes the flattened, channel-major activation map from transpose_module.
- Reduces each window sequentially, one element per cycle.
- Emits each pooled element on a stream port and the whole pooled frame on a flattened port.

Parameters:
- DATA_WIDTH, 8, element width.
- MAP_HEIGHT, 7, input map rows.
- MAP_WIDTH, 7, input map columns.
- NUM_CHANNELS, 6, feature maps per frame.
- POOL_SIZE, 2, window edge P; legal values 1, 2, 4, 8.
- POOL_STRIDE, 2, window step S; 1 <= S.
- SIGNED, 0, 1 = two's-complement compare and averaging.
- Derived, not overridable: OUT_H = (MAP_HEIGHT-1)/S + 1; OUT_W = (MAP_WIDTH-1)/S + 1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- valid_in, input, 1, frame-present strobe.
- pool_mode, input, 2, 0 = max, 1 = avg, 2 = min, 3 = subsample (top-left element).
- input_value, input, DATA_WIDTH*MAP_HEIGHT*MAP_WIDTH*NUM_CHANNELS, element (c,y,x) at LSB index ((c*MAP_HEIGHT+y)*MAP_WIDTH+x)*DATA_WIDTH.
- busy, output, 1, high from capture until frame done.
- elem_valid, output, 1, stream element valid.
- elem_ready, input, 1, stream consumer ready.
- elem_data, output, DATA_WIDTH, pooled element.
- elem_last, output, 1, marks the final element of the frame.
- out_value, output, DATA_WIDTH*OUT_H*OUT_W*NUM_CHANNELS, pooled frame; same channel-major layout using OUT_H/OUT_W.
- out_valid, output, 1, one-cycle pulse when out_value is updated.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - busy, elem_valid, elem_last, out_valid and elem_data are 0.
  - out_value and the internal frame buffer are all zeros.
  - State is IDLE.
- Reset mid-frame abandons the frame; no partial out_value update.
- IDLE:
  - valid_in=1 captures input_value and pool_mode into internal registers; busy=1 from the next cycle.
  - Counters reset: channel c, output row oy, output column ox, window row py, window column px. Next state is ACCUM.
- valid_in while busy is ignored. A pool_mode change mid-frame has no effect because the mode is latched at capture.
- ACCUM, exactly P*P cycles per window:
  - Element order: px inner, py outer.
  - Source coordinates: y = oy*S+py, x = ox*S+px.
  - Out-of-map elements (y >= MAP_HEIGHT or x >= MAP_WIDTH) are padding.
  - The first element (py=px=0) is always in-map. It initialises the accumulator for all modes.
- Per-mode rules:
  - max/min: padding is skipped. Comparison is signed when SIGNED=1.
  - avg: padding contributes 0. Accumulator width is DATA_WIDTH+2*log2(P). Result is sum >> 2*log2(P): arithmetic shift when SIGNED (floor), logical otherwise; truncated to DATA_WIDTH.
  - subsample: result is the first element; the remaining cycles still elapse, so timing is mode-independent.
- EMIT:
  - elem_valid=1 with elem_data = result.
  - elem_last=1 when c, oy and ox are all at their final values.
  - elem_data and elem_last stay stable while elem_ready=0.
  - On elem_valid && elem_ready: write the result into the frame buffer slot (c,oy,ox) and advance ox, then oy, then c. Go to ACCUM next cycle, or to DONE after the last element.
  - elem_ready is don't-care outside EMIT.
- DONE, one cycle:
  - out_value <= frame buffer; out_valid=1; busy=0 next cycle; then IDLE.
  - out_value holds until the next DONE, so it is stable throughout the following frame.
- Timing:
  - valid_in sampled at cycle 0 → first elem_valid at cycle P*P+1.
  - With elem_ready held at 1, each element costs P*P+1 cycles.
  - out_valid asserts one cycle after the last handshake.
- P=1: ACCUM is 1 cycle and all modes equal a copy (with S>1 this decimates).

Decomposition:
- Package pool_pkg:
  - Mode encodings: POOL_MAX, POOL_AVG, POOL_MIN, POOL_SUB.
  - FSM state enum.
  - clog2 function.
  - Functions for the OUT_H/OUT_W derivation.
- Sub-module pool_reducer:
  - Datapath holding the accumulator and signed/unsigned compare, plus a final-shift block.
  - Inputs: init, en, pad, mode, element. Output: result.
- The parent multi_pool_unit holds the FSM, counters, element indexing, frame buffer and stream handshake.

Test Plan:
- All tests use MAP 3x3, 2 channels, P=2, S=2, DATA_WIDTH=8 (OUT 2x2). Channel0 holds values 1..9 row-major; channel1 holds 10..18.
- Mode 0 (max), elem_ready=1 → stream 5,6,8,9,14,15,17,18; elem_last on the 8th element; out_valid one cycle later. out_value channel0 equals {9,8,6,5} from MSB to LSB.
- Mode 1 (avg) → channel0 3,2,3,2 (sums 12,9,15,9 over 4). Mode 2 (min) → 1,3,7,9. Mode 3 (subsample) → 1,3,7,9.
- SIGNED=1, window {0xFF,0x80,0x01,0x7F}: max → 0x7F; SIGNED=0 max → 0xFF. SIGNED=1, {-1,-1,-1,-2} avg → 0xFE.
- Backpressure:
  - Hold elem_ready=0 for 5 cycles during the 2nd element → elem_valid and elem_data stay constant and no counter advances.
  - Total frame time grows by exactly 5 cycles.
  - valid_in pulsed mid-frame with a new image → ignored; results unchanged.
- Reset mid-frame:
  - Assert rst at the 3rd EMIT → next cycle busy=0, elem_valid=0, out_value=0, no out_valid.
  - A following valid_in runs a full correct frame.
